hazard_monitor: RTL and testbench

//  Parametrised successor to the per-level pool checker. Tests N hazard pools against P player bounding boxes.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_player_fsm.sv | 79 +++++++
 rtl/hazard_monitor.sv | 119 +++++++++++
 tb/tb_hazard_monitor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: types and helpers shared by hazard_monitor and hazard_player_fsm.
//   MAX_HAZ      upper bound on the number of hazard pools (sizes kill_idx)
//   ply_state_e  per-player life state
//   bbox_t       signed player bounding box
//   overlap()    strict rectangle overlap test against one pool
package hazard_pkg;

  localparam int MAX_HAZ = 16;
  localparam int IDX_W   = $clog2(MAX_HAZ);

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    TOUCH = 2'd1,
    DEAD  = 2'd2
  } ply_state_e;

  typedef struct packed {
    logic signed [15:0] top;
    logic signed [15:0] bottom;
    logic signed [15:0] left;
    logic signed [15:0] right;
  } bbox_t;

  // Far edges are formed 17 bits wide so a pool near +32767 cannot wrap
  // negative. Touching edges do not count as overlap.
  function automatic logic overlap(bbox_t a, logic signed [15:0] x, logic signed [15:0] y,
                                   logic signed [15:0] w, logic signed [15:0] h);
    logic signed [16:0] xw;
    logic signed [16:0] yh;
    xw = 17'(x) + 17'(w);
    yh = 17'(y) + 17'(h);
    return (a.right > x) && (17'(a.left) < xw) &&
           (a.bottom > y) && (17'(a.top) < yh);
  endfunction

endpackage

// File: rtl/hazard_player_fsm.sv
// hazard_player_fsm: life state of one player with frame debounce.
//   Clk         system clock
//   clear       synchronous clear (Reset or restart), beats frame_tick
//   frame_tick  per-frame sampling strobe
//   lethal_any  player overlaps at least one non-immune pool
//   lethal_idx  lowest-index lethal pool this cycle
//   dead        sticky death flag (registered)
//   kill_idx    pool that caused the death, latched on the killing tick
//   dying       combinational: this tick moves the player into DEAD
module hazard_player_fsm
  import hazard_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic             Clk,
  input  logic             clear,
  input  logic             frame_tick,
  input  logic             lethal_any,
  input  logic [IDX_W-1:0] lethal_idx,
  output logic             dead,
  output logic [IDX_W-1:0] kill_idx,
  output logic             dying
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  ply_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge Clk) begin
    if (clear) begin
      state    <= ALIVE;
      cnt      <= '0;
      kill_idx <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (dying) kill_idx <= lethal_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dying     = 1'b0;
    if (frame_tick) begin
      unique case (state)
        ALIVE: begin
          if (lethal_any) begin
            cnt_nxt = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state_nxt = DEAD;
              dying     = 1'b1;
            end else begin
              state_nxt = TOUCH;
            end
          end
        end
        TOUCH: begin
          if (!lethal_any) begin
            state_nxt = ALIVE;
            cnt_nxt   = '0;
          end else if (int'(cnt) + 1 >= DEBOUNCE) begin
            state_nxt = DEAD;
            cnt_nxt   = CNT_W'(DEBOUNCE);
            dying     = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DEAD:    state_nxt = DEAD;
        default: state_nxt = ALIVE;
      endcase
    end
  end

  assign dead = (state == DEAD);

endmodule

// File: rtl/hazard_monitor.sv
// hazard_monitor: tests NUM_HAZ hazard pools against NUM_PLY player boxes
// once per frame, debounces kills, records the killing pool and sequences
// a delayed game-over.
//   Clk, Reset        clock, synchronous active-high reset
//   frame_tick        one-cycle per-frame sampling strobe
//   restart           synchronous level restart, same effect as Reset
//   ply_top/bottom/left/right  signed player boxes, one 16-bit lane per player
//   player_dead       sticky per-player death flags
//   kill_idx          killing pool per player, valid when player_dead[p]
//   first_dead        player that died first
//   game_over         sticky, GO_DELAY frames after the first death
//   game_over_pulse   one-cycle strobe on the game_over rise
module hazard_monitor
  import hazard_pkg::*;
#(
  parameter int                 NUM_HAZ    = 3,
  parameter int                 NUM_PLY    = 2,
  parameter int                 HAZ_W      = 80,
  parameter int                 HAZ_H      = 12,
  parameter shortint            HAZ_X      [NUM_HAZ] = '{296, 424, 392},
  parameter shortint            HAZ_Y      [NUM_HAZ] = '{463, 463, 366},
  parameter logic [NUM_PLY-1:0] HAZ_IMMUNE [NUM_HAZ] = '{2'b01, 2'b10, 2'b00},
  parameter int                 DEBOUNCE   = 2,
  parameter int                 GO_DELAY   = 60
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_tick,
  input  logic                          restart,
  input  logic [NUM_PLY-1:0][15:0]      ply_top,
  input  logic [NUM_PLY-1:0][15:0]      ply_bottom,
  input  logic [NUM_PLY-1:0][15:0]      ply_left,
  input  logic [NUM_PLY-1:0][15:0]      ply_right,
  output logic [NUM_PLY-1:0]            player_dead,
  output logic [NUM_PLY-1:0][IDX_W-1:0] kill_idx,
  output logic [1:0]                    first_dead,
  output logic                          game_over,
  output logic                          game_over_pulse
);

  localparam int GO_W = (GO_DELAY < 1) ? 1 : $clog2(GO_DELAY + 1);

  logic                      clr;
  logic [NUM_PLY-1:0][NUM_HAZ-1:0] lethal;
  logic [NUM_PLY-1:0]        lethal_any;
  logic [NUM_PLY-1:0][IDX_W-1:0] lethal_idx;
  logic [NUM_PLY-1:0]        dying;
  logic [1:0]                first_enc;
  logic                      death_seen;
  logic [GO_W-1:0]           go_cnt;

  assign clr = Reset | restart;

  for (genvar p = 0; p < NUM_PLY; p++) begin : g_ply
    bbox_t box;
    assign box = '{top: ply_top[p], bottom: ply_bottom[p], left: ply_left[p], right: ply_right[p]};

    for (genvar h = 0; h < NUM_HAZ; h++) begin : g_haz
      assign lethal[p][h] = overlap(box, HAZ_X[h], HAZ_Y[h], 16'(HAZ_W), 16'(HAZ_H))
                            && !HAZ_IMMUNE[h][p];
    end

    // Lowest-index lethal pool wins.
    always_comb begin
      lethal_idx[p] = '0;
      for (int h = NUM_HAZ - 1; h >= 0; h--) begin
        if (lethal[p][h]) lethal_idx[p] = IDX_W'(h);
      end
    end

    assign lethal_any[p] = |lethal[p];

    hazard_player_fsm #(.DEBOUNCE(DEBOUNCE)) u_fsm (
      .Clk        (Clk),
      .clear      (clr),
      .frame_tick (frame_tick),
      .lethal_any (lethal_any[p]),
      .lethal_idx (lethal_idx[p]),
      .dead       (player_dead[p]),
      .kill_idx   (kill_idx[p]),
      .dying      (dying[p])
    );
  end

  always_comb begin
    first_enc = '0;
    for (int p = NUM_PLY - 1; p >= 0; p--) begin
      if (dying[p]) first_enc = 2'(p);
    end
  end

  // The death tick itself starts the timer at zero; only later ticks count.
  always_ff @(posedge Clk) begin
    game_over_pulse <= 1'b0;
    if (clr) begin
      death_seen <= 1'b0;
      first_dead <= '0;
      go_cnt     <= '0;
      game_over  <= 1'b0;
    end else if (frame_tick) begin
      if (!death_seen && |dying) begin
        death_seen <= 1'b1;
        first_dead <= first_enc;
        go_cnt     <= '0;
        if (GO_DELAY == 0) begin
          game_over       <= 1'b1;
          game_over_pulse <= 1'b1;
        end
      end else if (death_seen && !game_over) begin
        go_cnt <= go_cnt + GO_W'(1);
        if (int'(go_cnt) + 1 == GO_DELAY) begin
          game_over       <= 1'b1;
          game_over_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_monitor.sv
// tb_hazard_monitor: directed scenarios for hazard_monitor with GO_DELAY=3.
// Stimulus pushes hand-computed expected outputs into a queue tagged with
// the cycle they apply to; an independent monitor pops and compares them.
module tb_hazard_monitor;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            frame_tick = 1'b0;
  logic            restart = 1'b0;
  logic [1:0][15:0] ply_top, ply_bottom, ply_left, ply_right;
  logic [1:0]      player_dead;
  logic [1:0][3:0] kill_idx;
  logic [1:0]      first_dead;
  logic            game_over;
  logic            game_over_pulse;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         due;
    string      nm;
    logic [1:0] dead;
    logic [3:0] k0;
    logic [3:0] k1;
    logic [1:0] first;
    logic       go;
    logic       pl;
  } exp_t;

  exp_t q[$];

  hazard_monitor #(.GO_DELAY(3)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_tick      (frame_tick),
    .restart         (restart),
    .ply_top         (ply_top),
    .ply_bottom      (ply_bottom),
    .ply_left        (ply_left),
    .ply_right       (ply_right),
    .player_dead     (player_dead),
    .kill_idx        (kill_idx),
    .first_dead      (first_dead),
    .game_over       (game_over),
    .game_over_pulse (game_over_pulse)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    exp_t e;
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (player_dead !== e.dead || kill_idx[0] !== e.k0 || kill_idx[1] !== e.k1 ||
          first_dead !== e.first || game_over !== e.go || game_over_pulse !== e.pl) begin
        n_bad++;
        $display("FAIL %s: got dead=%b k0=%0d k1=%0d first=%0d go=%b pulse=%b; want dead=%b k0=%0d k1=%0d first=%0d go=%b pulse=%b",
                 e.nm, player_dead, kill_idx[0], kill_idx[1], first_dead, game_over, game_over_pulse,
                 e.dead, e.k0, e.k1, e.first, e.go, e.pl);
      end
    end
  end

  task automatic step(input logic tk, input logic rs, input logic rst);
    @(negedge Clk);
    frame_tick = tk;
    restart    = rs;
    Reset      = rst;
    @(negedge Clk);
    frame_tick = 1'b0;
    restart    = 1'b0;
    Reset      = 1'b0;
  endtask

  task automatic exp_push(input string nm, input logic [1:0] d, input logic [3:0] k0,
                          input logic [3:0] k1, input logic [1:0] f, input logic go,
                          input logic pl);
    exp_t e;
    e.due = cyc; e.nm = nm; e.dead = d; e.k0 = k0; e.k1 = k1;
    e.first = f; e.go = go; e.pl = pl;
    q.push_back(e);
  endtask

  task automatic set_box(input int p, input int l, input int r, input int t, input int b);
    ply_left[p]   = 16'(l);
    ply_right[p]  = 16'(r);
    ply_top[p]    = 16'(t);
    ply_bottom[p] = 16'(b);
  endtask

  task automatic do_reset(input string nm);
    step(1'b0, 1'b0, 1'b1);
    exp_push(nm, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    set_box(0, 0, 10, 0, 10);
    set_box(1, 0, 10, 0, 10);
    do_reset("reset_state");

    // 1: P0 immune to pool 0
    set_box(0, 300, 320, 455, 470);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      exp_push($sformatf("t1_immune_%0d", i), 2'b00, 0, 0, 0, 0, 0);
    end

    // 2: P1 on pool 0, debounce then delayed game-over
    set_box(1, 300, 320, 455, 470);
    step(1, 0, 0); exp_push("t2_tick1",  2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t2_dead",   2'b10, 0, 0, 1, 0, 0);
    step(1, 0, 0); exp_push("t2_go_n1",  2'b10, 0, 0, 1, 0, 0);
    step(1, 0, 0); exp_push("t2_go_n2",  2'b10, 0, 0, 1, 0, 0);
    step(1, 0, 0); exp_push("t2_go_n3",  2'b10, 0, 0, 1, 1, 1);
    step(0, 0, 0); exp_push("t2_go_hold",2'b10, 0, 0, 1, 1, 0);
    step(0, 1, 0); exp_push("t2_restart",2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t2_rs_tick",2'b00, 0, 0, 0, 0, 0);

    // 3: debounce broken by a clear frame
    do_reset("t3_reset");
    set_box(1, 0, 10, 0, 10);
    set_box(0, 400, 420, 360, 370);
    step(1, 0, 0); exp_push("t3_on1",    2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 0); exp_push("t3_no_tick",2'b00, 0, 0, 0, 0, 0);
    set_box(0, 0, 10, 0, 10);
    step(1, 0, 0); exp_push("t3_off",    2'b00, 0, 0, 0, 0, 0);
    set_box(0, 400, 420, 360, 370);
    step(1, 0, 0); exp_push("t3_on3",    2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t3_dead",   2'b01, 2, 0, 0, 0, 0);

    // 4: edge-touching is not overlap
    do_reset("t4_reset");
    set_box(0, 404, 424, 465, 470);
    set_box(1, 276, 296, 465, 470);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      exp_push($sformatf("t4_edge424_%0d", i), 2'b00, 0, 0, 0, 0, 0);
    end
    set_box(0, 404, 425, 465, 470);
    step(1, 0, 0); exp_push("t4_p0_t1",  2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t4_p0_dead",2'b01, 1, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t4_edge296_a", 2'b01, 1, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t4_edge296_b", 2'b01, 1, 0, 0, 0, 0);
    set_box(1, 276, 297, 465, 470);
    step(1, 0, 0); exp_push("t4_go",     2'b01, 1, 0, 0, 1, 1);
    step(1, 0, 0); exp_push("t4_p1_dead",2'b11, 1, 0, 0, 1, 0);

    // 5: simultaneous deaths
    do_reset("t5_reset");
    set_box(0, 400, 420, 360, 370);
    set_box(1, 400, 420, 360, 370);
    step(1, 0, 0); exp_push("t5_t1",     2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t5_both",   2'b11, 2, 2, 0, 0, 0);

    // 6: restart/Reset beat a tick and clear the debounce count
    do_reset("t6_reset");
    set_box(1, 0, 10, 0, 10);
    step(1, 0, 0); exp_push("t6_touch",  2'b00, 0, 0, 0, 0, 0);
    step(1, 1, 0); exp_push("t6_rs_tick",2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t6_after_rs",2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 1); exp_push("t6_reset_mid",2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t6_single", 2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0); exp_push("t6_kill",   2'b01, 2, 0, 0, 0, 0);

    repeat (3) @(negedge Clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
